mcpu_control_fsm: RTL and testbench

Multi-cycle control unit sitting directly upstream of the 32-bit ALU. It sequences each instruction through IF/ID/EXE/MEM/WB states and drives ALUOp[2:0], the operand selects, and all datapath write enables. It consumes the ALU zero flag for branch resolution.

---
 rtl/mcpu_control_fsm.sv | 199 +++++++++++++++++++
 tb/tb_mcpu_control_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle control FSM for the 32-bit datapath: sequences IF/ID/EXE/MEM/WB and drives ALU and write-enable controls.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unlisted opcodes park in TRAP; otherwise they retire as a 2-cycle NOP.
//
// state  | meaning
// -------+-----------------------------------------------
// IF     | 0000 fetch, load IR
// ID     | 0001 decode; jumps retire here
// EXE_LS | 0010 address calc for lw/sw
// MEM    | 0011 data memory access
// WB_LD  | 0100 load writeback
// EXE_BR | 0101 branch compare and resolve
// EXE_AL | 0110 ALU execute
// WB_AL  | 0111 ALU writeback
// HALT   | 1000 parked until reset
// TRAP   | 1001 illegal opcode, parked until reset
module mcpu_control_fsm #(
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic       PCWre,
   output logic       IRWre,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtSel,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic [1:0] PCSrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_LS = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB_LD  = 4'b0100,
      S_EXE_BR = 4'b0101,
      S_EXE_AL = 4'b0110,
      S_WB_AL  = 4'b0111,
      S_HALT   = 4'b1000,
      S_TRAP   = 4'b1001
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_XOR  = 6'b010011, OP_SLL  = 6'b011000, OP_SLTU = 6'b100110;
   localparam logic [5:0] OP_SLT  = 6'b100111, OP_BEQ  = 6'b110100, OP_BLTZ = 6'b110110;
   localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001, OP_JAL  = 6'b111010;

   state_t r_state;
   state_t w_next;
   logic   w_taken;
   logic   w_itype;

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IF;
      else     r_state <= w_next;
   end

   assign state   = r_state;
   assign w_taken = (opcode == OP_BEQ) ? zero : ~zero;
   assign w_itype = (opcode == OP_ADDI) || (opcode == OP_ORI);

   always_comb begin
      w_next    = r_state;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      ExtSel    = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      PCSrc     = 2'b00;
      case (r_state)
         S_IF: begin
            IRWre  = 1'b1;
            w_next = S_ID;
         end
         S_ID: begin
            if (opcode == HALT_OP) begin
               w_next = S_HALT;
            end else begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                  OP_XOR, OP_SLL, OP_SLTU, OP_SLT: w_next = S_EXE_AL;
                  OP_BEQ, OP_BLTZ:                 w_next = S_EXE_BR;
                  OP_SW, OP_LW:                    w_next = S_EXE_LS;
                  OP_J: begin
                     PCWre  = 1'b1;
                     PCSrc  = 2'b11;
                     w_next = S_IF;
                  end
                  OP_JR: begin
                     PCWre  = 1'b1;
                     PCSrc  = 2'b10;
                     w_next = S_IF;
                  end
                  OP_JAL: begin
                     PCWre     = 1'b1;
                     PCSrc     = 2'b11;
                     RegWre    = 1'b1;
                     RegDst    = 2'b00;
                     WrRegDSrc = 1'b0;
                     w_next    = S_IF;
                  end
                  default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     w_next = S_TRAP;
`else
                     PCWre  = 1'b1;
                     w_next = S_IF;
`endif
                  end
               endcase
            end
         end
         S_EXE_AL: begin
            case (opcode)
               OP_SUB:         ALUOp = 3'b001;
               OP_SLTU:        ALUOp = 3'b010;
               OP_SLT:         ALUOp = 3'b011;
               OP_SLL:         ALUOp = 3'b100;
               OP_OR, OP_ORI:  ALUOp = 3'b101;
               OP_AND:         ALUOp = 3'b110;
               OP_XOR:         ALUOp = 3'b111;
               default:        ALUOp = 3'b000;
            endcase
            ALUSrcA = (opcode == OP_SLL);
            ALUSrcB = w_itype;
            ExtSel  = (opcode == OP_ADDI);
            w_next  = S_WB_AL;
         end
         S_WB_AL: begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = w_itype ? 2'b01 : 2'b10;
            PCWre     = 1'b1;
            w_next    = S_IF;
         end
         S_EXE_BR: begin
            ALUOp  = (opcode == OP_BEQ) ? 3'b001 : 3'b011;
            PCWre  = 1'b1;
            PCSrc  = w_taken ? 2'b01 : 2'b00;
            w_next = S_IF;
         end
         S_EXE_LS: begin
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
            w_next  = S_MEM;
         end
         S_MEM: begin
            if (opcode == OP_LW) begin
               mRD    = 1'b1;
               w_next = S_WB_LD;
            end else begin
               mWR    = 1'b1;
               PCWre  = 1'b1;
               w_next = S_IF;
            end
         end
         S_WB_LD: begin
            RegWre    = 1'b1;
            RegDst    = 2'b01;
            DBDataSrc = 1'b1;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
            w_next    = S_IF;
         end
         S_HALT:  w_next = S_HALT;
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_IF;
      endcase
      // Reset overrides everything so an aborted instruction cannot write.
      if (RST) begin
         PCWre  = 1'b0;
         IRWre  = 1'b0;
         RegWre = 1'b0;
         mRD    = 1'b0;
         mWR    = 1'b0;
         ALUOp  = 3'b000;
         PCSrc  = 2'b00;
      end
   end

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Directed testbench for mcpu_control_fsm; follows CTRL_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_mcpu_control_fsm;

   logic       CLK, RST, zero;
   logic [5:0] opcode;
   logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre;
   logic       WrRegDSrc, DBDataSrc, mRD, mWR;
   logic [2:0] ALUOp;
   logic [1:0] RegDst, PCSrc;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   mcpu_control_fsm dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
      .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst),
      .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
      .PCSrc(PCSrc), .state(state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; opcode = 6'b000000; zero = 1'b0;
      tick(); tick();
      checks++;
      if (state !== 4'b0000) begin $display("FAIL reset_state: got %b expected 0000", state); errors++; end
      checks++;
      if ({PCWre, IRWre, RegWre, mRD, mWR} !== 5'b0) begin
         $display("FAIL reset_enables: got %b expected 00000", {PCWre, IRWre, RegWre, mRD, mWR}); errors++;
      end
      checks++;
      if ({ALUOp, PCSrc} !== 5'b0) begin $display("FAIL reset_aluop_pcsrc: got %b expected 00000", {ALUOp, PCSrc}); errors++; end
      RST = 1'b0; #1;
      checks++;
      if (IRWre !== 1'b1) begin $display("FAIL reset_release_irwre: got %b expected 1", IRWre); errors++; end
      // abort an add in WB_AL: reset must suppress the write
      tick(); tick(); tick();
      checks++;
      if (state !== 4'b0111) begin $display("FAIL abort_reach_wb: got %b expected 0111", state); errors++; end
      RST = 1'b1; #1;
      checks++;
      if ({RegWre, PCWre} !== 2'b00) begin $display("FAIL abort_no_write: got %b expected 00", {RegWre, PCWre}); errors++; end
      tick();
      checks++;
      if (state !== 4'b0000) begin $display("FAIL abort_state: got %b expected 0000", state); errors++; end
      RST = 1'b0; #1;
   endtask

   task automatic test_add();
      logic [3:0] exp_st [5];
      exp_st = '{4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b0000};
      opcode = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state !== exp_st[i]) begin $display("FAIL add_state[%0d]: got %b expected %b", i, state, exp_st[i]); errors++; end
         checks++;
         if ({RegWre, PCWre} !== {2{i == 3}}) begin
            $display("FAIL add_we[%0d]: got %b expected %b", i, {RegWre, PCWre}, {2{i == 3}}); errors++;
         end
         if (i == 2) begin
            checks++;
            if (ALUOp !== 3'b000) begin $display("FAIL add_aluop: got %b expected 000", ALUOp); errors++; end
         end
         if (i == 3) begin
            checks++;
            if ({RegDst, WrRegDSrc, DBDataSrc, PCSrc} !== 6'b10_1_0_00) begin
               $display("FAIL add_wb_ctrl: got %b expected 101000", {RegDst, WrRegDSrc, DBDataSrc, PCSrc}); errors++;
            end
         end
         if (i < 4) tick();
      end
   endtask

   task automatic test_alu_ops();
      logic [5:0] ops [9];
      logic [2:0] aop [9];
      ops = '{6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111};
      aop = '{3'b001,    3'b000,    3'b101,    3'b110,    3'b101,    3'b111,    3'b100,    3'b010,    3'b011};
      for (int i = 0; i < 9; i++) begin
         logic itype;
         opcode = ops[i];
         itype  = (ops[i] == 6'b000010) || (ops[i] == 6'b010010);
         tick(); tick();
         checks++;
         if (state !== 4'b0110) begin $display("FAIL alu_state[%0d]: got %b expected 0110", i, state); errors++; end
         checks++;
         if ({ALUOp, ALUSrcA, ALUSrcB} !== {aop[i], ops[i] == 6'b011000, itype}) begin
            $display("FAIL alu_exe[%0d]: got %b expected %b", i, {ALUOp, ALUSrcA, ALUSrcB}, {aop[i], ops[i] == 6'b011000, itype}); errors++;
         end
         if (itype) begin
            checks++;
            if (ExtSel !== (ops[i] == 6'b000010)) begin
               $display("FAIL alu_extsel[%0d]: got %b expected %b", i, ExtSel, ops[i] == 6'b000010); errors++;
            end
         end
         tick();
         checks++;
         if (RegDst !== (itype ? 2'b01 : 2'b10)) begin
            $display("FAIL alu_regdst[%0d]: got %b expected %b", i, RegDst, itype ? 2'b01 : 2'b10); errors++;
         end
         tick();
      end
   endtask

   task automatic test_load_store();
      logic [3:0] lw_st [6];
      lw_st  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0000};
      opcode = 6'b110001;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (state !== lw_st[i]) begin $display("FAIL lw_state[%0d]: got %b expected %b", i, state, lw_st[i]); errors++; end
         checks++;
         if ({mRD, mWR, RegWre, DBDataSrc, PCWre} !== {i == 3, 1'b0, i == 4, i == 4, i == 4}) begin
            $display("FAIL lw_ctrl[%0d]: got %b expected %b", i, {mRD, mWR, RegWre, DBDataSrc, PCWre}, {i == 3, 1'b0, i == 4, i == 4, i == 4}); errors++;
         end
         if (i == 2) begin
            checks++;
            if ({ALUOp, ALUSrcB, ExtSel} !== 5'b000_1_1) begin $display("FAIL lw_exe: got %b expected 00011", {ALUOp, ALUSrcB, ExtSel}); errors++; end
         end
         if (i == 4) begin
            checks++;
            if ({RegDst, WrRegDSrc} !== 3'b01_1) begin $display("FAIL lw_wb: got %b expected 011", {RegDst, WrRegDSrc}); errors++; end
         end
         if (i < 5) tick();
      end
      opcode = 6'b110000;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state !== lw_st[i == 4 ? 5 : i]) begin $display("FAIL sw_state[%0d]: got %b", i, state); errors++; end
         checks++;
         if ({mWR, mRD, RegWre, PCWre} !== {i == 3, 1'b0, 1'b0, i == 3}) begin
            $display("FAIL sw_ctrl[%0d]: got %b expected %b", i, {mWR, mRD, RegWre, PCWre}, {i == 3, 1'b0, 1'b0, i == 3}); errors++;
         end
         if (i < 4) tick();
      end
   endtask

   task automatic test_branch();
      logic [5:0] ops [4];
      logic       zs  [4];
      logic [1:0] src [4];
      logic [2:0] aop [4];
      ops = '{6'b110100, 6'b110100, 6'b110110, 6'b110110};
      zs  = '{1'b1,      1'b0,      1'b0,      1'b1};
      src = '{2'b01,     2'b00,     2'b01,     2'b00};
      aop = '{3'b001,    3'b001,    3'b011,    3'b011};
      for (int i = 0; i < 4; i++) begin
         opcode = ops[i]; zero = zs[i];
         tick(); tick();
         checks++;
         if (state !== 4'b0101) begin $display("FAIL br_state[%0d]: got %b expected 0101", i, state); errors++; end
         checks++;
         if ({PCWre, PCSrc, ALUOp} !== {1'b1, src[i], aop[i]}) begin
            $display("FAIL br_ctrl[%0d]: got %b expected %b", i, {PCWre, PCSrc, ALUOp}, {1'b1, src[i], aop[i]}); errors++;
         end
         tick();
         checks++;
         if (state !== 4'b0000) begin $display("FAIL br_done[%0d]: got %b expected 0000", i, state); errors++; end
      end
      zero = 1'b0;
   endtask

   task automatic test_jump();
      logic [5:0] ops [3];
      logic [1:0] src [3];
      ops = '{6'b111000, 6'b111001, 6'b111010};
      src = '{2'b11,     2'b10,     2'b11};
      for (int i = 0; i < 3; i++) begin
         opcode = ops[i];
         tick();
         checks++;
         if ({PCWre, PCSrc, RegWre} !== {1'b1, src[i], i == 2}) begin
            $display("FAIL jmp_id[%0d]: got %b expected %b", i, {PCWre, PCSrc, RegWre}, {1'b1, src[i], i == 2}); errors++;
         end
         if (i == 2) begin
            checks++;
            if ({RegDst, WrRegDSrc} !== 3'b000) begin $display("FAIL jal_link: got %b expected 000", {RegDst, WrRegDSrc}); errors++; end
         end
         tick();
         checks++;
         if (state !== 4'b0000) begin $display("FAIL jmp_done[%0d]: got %b expected 0000", i, state); errors++; end
      end
   endtask

   task automatic test_park(input logic [5:0] op, input logic [3:0] park_st, input string name);
      opcode = op;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({state, PCWre, IRWre, RegWre, mRD, mWR} !== {park_st, 5'b0}) begin
            $display("FAIL %s_hold[%0d]: got %b expected %b", name, i, {state, PCWre, IRWre, RegWre, mRD, mWR}, {park_st, 5'b0}); errors++;
         end
         tick();
      end
      RST = 1'b1; tick(); RST = 1'b0; #1;
      checks++;
      if (state !== 4'b0000) begin $display("FAIL %s_reset: got %b expected 0000", name, state); errors++; end
   endtask

   task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
      test_park(6'b001111, 4'b1001, "trap");
`else
      opcode = 6'b001111;
      tick();
      checks++;
      if ({state, PCWre, PCSrc, RegWre} !== {4'b0001, 1'b1, 2'b00, 1'b0}) begin
         $display("FAIL nop_id: got %b expected 0001_1_00_0", {state, PCWre, PCSrc, RegWre}); errors++;
      end
      tick();
      checks++;
      if (state !== 4'b0000) begin $display("FAIL nop_done: got %b expected 0000", state); errors++; end
`endif
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [5];
      int         lat [5];
      int         pulses;
      ops = '{6'b000000, 6'b110001, 6'b110100, 6'b111010, 6'b110000};
      lat = '{4, 5, 3, 2, 4};
      pulses = 0;
      zero = 1'b1;
      for (int k = 0; k < 5; k++) begin
         opcode = ops[k];
         for (int c = 0; c < lat[k]; c++) begin
            checks++;
            if (mRD && mWR) begin $display("FAIL b2b_mem_excl[%0d.%0d]: got mRD=1 mWR=1 expected not both", k, c); errors++; end
            if (PCWre) pulses++;
            tick();
         end
         checks++;
         if (state !== 4'b0000) begin $display("FAIL b2b_done[%0d]: got %b expected 0000", k, state); errors++; end
      end
      checks++;
      if (pulses !== 5) begin $display("FAIL b2b_pcwre_count: got %0d expected 5", pulses); errors++; end
      zero = 1'b0;
   endtask

   initial begin
      RST = 1'b1; opcode = 6'b000000; zero = 1'b0;
      test_reset();
      test_add();
      test_alu_ops();
      test_load_store();
      test_branch();
      test_jump();
      test_illegal();
      test_park(6'b111111, 4'b1000, "halt");
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
